// File: rtl/tick_period_meter_pkg.sv
// Shared types and defaults for the tick period meter.
package tick_period_meter_pkg;
  localparam int DEF_SRC_FREQ = 5000;
  localparam int DEF_CNT_W    = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_MEASURE,
    ST_STALL
  } state_t;
endpackage

// File: rtl/tick_period_meter_if.sv
// Control/result bundle between a tick consumer and the period meter.
interface tick_period_meter_if #(
  parameter int CNT_W = tick_period_meter_pkg::DEF_CNT_W
);
  logic             enable;
  logic             tick_in;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             period_valid;
  logic             locked;
  logic             stalled;

  modport master (
    output enable, tick_in,
    input  period, high_time, period_valid, locked, stalled
  );

  modport slave (
    input  enable, tick_in,
    output period, high_time, period_valid, locked, stalled
  );
endinterface

// File: rtl/tick_period_meter_sync_edge_det.sv
// Multi-flop synchronizer for an async level, with registered rise/fall pulses.
module tick_period_meter_sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_rise,
  output logic o_fall
);
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_lvl;
  logic                   r_rise;
  logic                   r_fall;
  logic                   w_sync;

  assign w_sync = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_lvl  <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
      r_lvl  <= w_sync;
      r_rise <= w_sync & ~r_lvl;
      r_fall <= ~w_sync & r_lvl;
    end
  end

  assign o_rise = r_rise;
  assign o_fall = r_fall;
endmodule

// File: rtl/tick_period_meter.sv
// Measures period and high time of a slow async tick, tracks lock and stall.
module tick_period_meter
  import tick_period_meter_pkg::*;
#(
  parameter int SRC_FREQ    = DEF_SRC_FREQ,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = SRC_FREQ * 2,
  parameter int TOL         = 1,
  parameter int LOCK_COUNT  = 3
) (
  input  logic                src_clk,
  input  logic                rst_n,
  tick_period_meter_if.slave  bus
);
  localparam int MC_W = (LOCK_COUNT < 1) ? 1 : $clog2(LOCK_COUNT + 1);
  localparam logic [MC_W-1:0]  LOCK_MC = MC_W'(LOCK_COUNT);
  localparam logic [CNT_W-1:0] TO_CNT  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] TOL_CNT = CNT_W'(TOL);

  logic w_rise, w_fall, w_high, w_match;
  logic [CNT_W-1:0] w_diff;
  logic [MC_W-1:0]  w_mc_inc;

  state_t           r_st, w_st;
  logic [CNT_W-1:0] r_cnt, w_cnt, r_hi_cnt, w_hi_cnt, r_prev, w_prev;
  logic [CNT_W-1:0] r_period, w_period, r_high_time, w_high_time;
  logic [MC_W-1:0]  r_mc, w_mc;
  logic             r_prev_vld, w_prev_vld, r_valid, w_valid;
  logic             r_locked, w_locked, r_stalled, w_stalled, r_in_high;

  tick_period_meter_sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk    (src_clk),
    .rst_n  (rst_n),
    .i_d    (bus.tick_in),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  // Synchronized level rebuilt from the edge pulses: high from rise until fall.
  assign w_high   = w_rise | (r_in_high & ~w_fall);
  assign w_diff   = (r_cnt >= r_prev) ? (r_cnt - r_prev) : (r_prev - r_cnt);
  assign w_match  = r_prev_vld && (w_diff <= TOL_CNT);
  assign w_mc_inc = (r_mc >= LOCK_MC) ? r_mc : r_mc + 1'b1;

  always_comb begin
    w_st        = r_st;
    w_cnt       = r_cnt;
    w_hi_cnt    = r_hi_cnt;
    w_prev      = r_prev;
    w_prev_vld  = r_prev_vld;
    w_mc        = r_mc;
    w_period    = r_period;
    w_high_time = r_high_time;
    w_valid     = 1'b0;
    w_locked    = r_locked;
    w_stalled   = r_stalled;
    if (!bus.enable) begin
      w_st       = ST_IDLE;
      w_cnt      = '0;
      w_hi_cnt   = '0;
      w_mc       = '0;
      w_prev_vld = 1'b0;
      w_locked   = 1'b0;
      w_stalled  = 1'b0;
    end else begin
      case (r_st)
        ST_IDLE: w_st = ST_ARM;
        ST_ARM, ST_MEASURE: begin
          if (w_rise) begin
            w_st     = ST_MEASURE;
            w_cnt    = CNT_W'(1);
            w_hi_cnt = CNT_W'(1);
            if (r_st == ST_MEASURE) begin
              w_period    = r_cnt;
              w_high_time = r_hi_cnt;
              w_valid     = 1'b1;
              w_prev      = r_cnt;
              w_prev_vld  = 1'b1;
              w_mc        = w_match ? w_mc_inc : '0;
              w_locked    = w_match && (w_mc_inc >= LOCK_MC);
            end
          end else if (r_cnt >= TO_CNT) begin
            // Edge on the same cycle as the timeout is handled above and wins.
            w_st        = ST_STALL;
            w_cnt       = TO_CNT;
            w_mc        = '0;
            w_prev_vld  = 1'b0;
            w_period    = '0;
            w_high_time = '0;
            w_locked    = 1'b0;
            w_stalled   = 1'b1;
          end else begin
            w_cnt    = r_cnt + 1'b1;
            w_hi_cnt = r_hi_cnt + CNT_W'(w_high);
          end
        end
        ST_STALL: begin
          w_cnt = TO_CNT;
          if (w_rise) begin
            w_st      = ST_MEASURE;
            w_cnt     = CNT_W'(1);
            w_hi_cnt  = CNT_W'(1);
            w_stalled = 1'b0;
          end
        end
        default: w_st = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge src_clk) begin
    if (!rst_n) begin
      r_st        <= ST_IDLE;
      r_cnt       <= '0;
      r_hi_cnt    <= '0;
      r_prev      <= '0;
      r_prev_vld  <= 1'b0;
      r_mc        <= '0;
      r_period    <= '0;
      r_high_time <= '0;
      r_valid     <= 1'b0;
      r_locked    <= 1'b0;
      r_stalled   <= 1'b0;
      r_in_high   <= 1'b0;
    end else begin
      r_st        <= w_st;
      r_cnt       <= w_cnt;
      r_hi_cnt    <= w_hi_cnt;
      r_prev      <= w_prev;
      r_prev_vld  <= w_prev_vld;
      r_mc        <= w_mc;
      r_period    <= w_period;
      r_high_time <= w_high_time;
      r_valid     <= w_valid;
      r_locked    <= w_locked;
      r_stalled   <= w_stalled;
      r_in_high   <= w_high;
    end
  end

  assign bus.period       = r_period;
  assign bus.high_time    = r_high_time;
  assign bus.period_valid = r_valid;
  assign bus.locked       = r_locked;
  assign bus.stalled      = r_stalled;
endmodule
